// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch unit: owns the PC and issues one fetch at a time.
// Hands each fetched word and its PC to decode; drops fetches on the old path after a redirect.
module ysyx_22040127_ifu #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            kill, kill_n;
    logic [31:0]     inst_q, inst_n;
    logic [XLEN-1:0] inst_pc_q, inst_pc_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            kill      <= kill_n;
            inst_q    <= inst_n;
            inst_pc_q <= inst_pc_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        kill_n    = kill;
        inst_n    = inst_q;
        inst_pc_n = inst_pc_q;

        unique case (state)
            IDLE: state_n = REQ;
            REQ: begin
                if (imem_req_ready) state_n = WAIT;
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    if (kill) begin
                        kill_n  = 1'b0;
                        state_n = REQ;
                    end else begin
                        inst_n    = imem_resp_data;
                        inst_pc_n = pc;
                        state_n   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    pc_n    = pc + XLEN'(4);
                    state_n = REQ;
                end
            end
            default: state_n = IDLE;
        endcase

        // Redirect overrides the normal transition; an accepted old-path fetch is marked dead.
        if (redirect_valid) begin
            pc_n      = {redirect_pc[XLEN-1:2], 2'b00};
            inst_n    = inst_q;
            inst_pc_n = inst_pc_q;
            unique case (state)
                IDLE: state_n = REQ;
                REQ: begin
                    if (imem_req_ready) begin
                        state_n = WAIT;
                        kill_n  = 1'b1;
                    end else begin
                        state_n = REQ;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        state_n = REQ;
                        kill_n  = 1'b0;
                    end else begin
                        state_n = WAIT;
                        kill_n  = 1'b1;
                    end
                end
                HOLD: state_n = REQ;
                default: state_n = IDLE;
            endcase
        end
    end

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == HOLD);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ysyx_22040127_ifu.sv
// Self-checking bench for ysyx_22040127_ifu.
// A transaction-level model tracks the next fetch PC and the instruction decode should see.
module tb_ysyx_22040127_ifu;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    int n_chk = 0;
    int n_err = 0;

    // model: m_idle = one dead cycle after reset, m_out = fetch outstanding,
    // m_live = outstanding fetch still wanted, m_hold = decode owes a handshake
    logic        m_ok = 1'b0;
    logic        m_idle, m_out, m_live, m_hold;
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_inst;

    ysyx_22040127_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // one clock: drive inputs, compare outputs with model, advance model
    task automatic cyc(input logic rs, input logic rdy, input logic resp,
                       input logic [31:0] data, input logic ir,
                       input logic rv, input logic [63:0] rpc);
        logic acc, cons, old_out, exp_rv;
        rst             = rs;
        imem_req_ready  = rdy;
        imem_resp_valid = resp;
        imem_resp_data  = data;
        inst_ready      = ir;
        redirect_valid  = rv;
        redirect_pc     = rpc;
        #1;
        if (m_ok) begin
            exp_rv = !m_idle && !m_out && !m_hold;
            n_chk++;
            if (imem_req_valid !== exp_rv) begin
                n_err++;
                $display("FAIL model_req_valid got %b want %b", imem_req_valid, exp_rv);
            end
            n_chk++;
            if (imem_req_addr !== m_pc) begin
                n_err++;
                $display("FAIL model_addr got %h want %h", imem_req_addr, m_pc);
            end
            n_chk++;
            if (inst_valid !== m_hold) begin
                n_err++;
                $display("FAIL model_inst_valid got %b want %b", inst_valid, m_hold);
            end
            n_chk++;
            if (inst !== m_inst || inst_pc !== m_ipc) begin
                n_err++;
                $display("FAIL model_inst got %h@%h want %h@%h", inst, inst_pc, m_inst, m_ipc);
            end
        end
        if (rs) begin
            m_ok   = 1'b1;
            m_idle = 1'b1;
            m_out  = 1'b0;
            m_live = 1'b0;
            m_hold = 1'b0;
            m_pc   = RPC;
            m_inst = '0;
            m_ipc  = '0;
        end else if (m_ok) begin
            acc     = !m_idle && !m_out && !m_hold && rdy;
            cons    = m_hold && ir && !rv;
            old_out = m_out;
            m_idle  = 1'b0;
            if (acc) begin
                m_out  = 1'b1;
                m_live = 1'b1;
            end
            if (old_out && resp) begin
                m_out = 1'b0;
                if (m_live && !rv) begin
                    m_hold = 1'b1;
                    m_inst = data;
                    m_ipc  = m_pc;
                end
                m_live = 1'b0;
            end
            if (cons) begin
                m_hold = 1'b0;
                m_pc   = m_pc + 64'd4;
            end
            if (rv) begin
                m_pc   = {rpc[63:2], 2'b00};
                m_hold = 1'b0;
                m_live = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle1();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle1();
    endtask

    task automatic test_reset();
        cyc(1, 1, 1, 32'hdead_beef, 1, 1, 64'h1234);
        n_chk++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
            inst_pc !== 64'h0 || imem_req_addr !== RPC) begin
            n_err++;
            $display("FAIL reset got rv=%b iv=%b inst=%h ipc=%h addr=%h want 0 0 0 0 %h",
                     imem_req_valid, inst_valid, inst, inst_pc, imem_req_addr, RPC);
        end
        idle1();
        n_chk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC) begin
            n_err++;
            $display("FAIL reset_first_req got %b@%h want 1@%h",
                     imem_req_valid, imem_req_addr, RPC);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] d;
        logic [63:0] a;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            a = RPC + 64'(4 * i);
            n_chk++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin
                n_err++;
                $display("FAIL zw_req%0d got %b@%h want 1@%h", i, imem_req_valid, imem_req_addr, a);
            end
            cyc(0, 1, 0, 0, 0, 0, 0);
            cyc(0, 0, 1, d, 0, 0, 0);
            n_chk++;
            if (inst_valid !== 1'b1 || inst !== d || inst_pc !== a) begin
                n_err++;
                $display("FAIL zw_inst%0d got %b %h@%h want 1 %h@%h", i, inst_valid, inst, inst_pc, d, a);
            end
            cyc(0, 0, 0, 0, 1, 0, 0);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        d = $urandom;
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, d, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (inst_valid !== 1'b1 || inst !== d || inst_pc !== RPC || imem_req_valid !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold%0d got %b %h@%h req=%b want 1 %h@%h req=0",
                         i, inst_valid, inst, inst_pc, imem_req_valid, d, RPC);
            end
            cyc(0, 1, 0, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 0, 1, 0, 0);
        n_chk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== RPC + 64'd4) begin
            n_err++;
            $display("FAIL bp_release got %b@%h want 1@%h", imem_req_valid, imem_req_addr, RPC + 64'd4);
        end
    endtask

    task automatic test_redirect_wait();
        logic [31:0] d;
        d = $urandom;
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 64'h8000_1002);
        idle1();
        idle1();
        cyc(0, 0, 1, 32'hbad0_0bad, 1, 0, 0);
        n_chk++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000) begin
            n_err++;
            $display("FAIL rw_drop got iv=%b %b@%h want iv=0 1@80001000",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, d, 0, 0, 0);
        n_chk++;
        if (inst_valid !== 1'b1 || inst !== d || inst_pc !== 64'h8000_1000) begin
            n_err++;
            $display("FAIL rw_new got %b %h@%h want 1 %h@80001000", inst_valid, inst, inst_pc, d);
        end
        cyc(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_redirect_hold();
        do_reset();
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, $urandom, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 64'h8000_0100);
        n_chk++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin
            n_err++;
            $display("FAIL rh got iv=%b %b@%h want iv=0 1@80000100",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_redirect_req();
        logic [31:0] d;
        d = $urandom;
        do_reset();
        cyc(0, 1, 0, 0, 0, 1, 64'h8000_0200);
        n_chk++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 64'h8000_0200) begin
            n_err++;
            $display("FAIL rq_wait got %b@%h want 0@80000200", imem_req_valid, imem_req_addr);
        end
        cyc(0, 0, 1, 32'hbad1_1bad, 1, 0, 0);
        n_chk++;
        if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin
            n_err++;
            $display("FAIL rq_drop got iv=%b %b@%h want iv=0 1@80000200",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, d, 0, 0, 0);
        n_chk++;
        if (inst_valid !== 1'b1 || inst !== d || inst_pc !== 64'h8000_0200) begin
            n_err++;
            $display("FAIL rq_new got %b %h@%h want 1 %h@80000200", inst_valid, inst, inst_pc, d);
        end
        cyc(0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_reset_wait();
        do_reset();
        cyc(0, 0, 0, 0, 0, 1, 64'h8000_0400);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 32'h1357_9bdf, 1, 1, 64'h8000_0800);
        n_chk++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_req_addr !== RPC || inst !== 32'h0) begin
            n_err++;
            $display("FAIL rst_wait got %b@%h iv=%b inst=%h want 0@%h iv=0 inst=0",
                     imem_req_valid, imem_req_addr, inst_valid, inst, RPC);
        end
        idle1();
        n_chk++;
        if (imem_req_valid !== 1'b1 || inst_valid !== 1'b0 || imem_req_addr !== RPC) begin
            n_err++;
            $display("FAIL rst_wait_req got %b@%h iv=%b want 1@%h iv=0",
                     imem_req_valid, imem_req_addr, inst_valid, RPC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        d = $urandom;
        do_reset();
        cyc(0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE);
        n_chk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_top got %b@%h want 1@fffffffffffffffc", imem_req_valid, imem_req_addr);
        end
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, d, 0, 0, 0);
        n_chk++;
        if (inst !== d || inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_inst got %h@%h want %h@fffffffffffffffc", inst, inst_pc, d);
        end
        cyc(0, 0, 0, 0, 1, 0, 0);
        n_chk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h0) begin
            n_err++;
            $display("FAIL wrap_zero got %b@%h want 1@0", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_random();
        int          wcnt;
        logic        rs, rdy, resp, ir, rv;
        logic [63:0] rpc;
        wcnt = 0;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rs   = ($urandom_range(0, 299) == 0);
            rdy  = 1'($urandom_range(0, 1));
            ir   = 1'($urandom_range(0, 1));
            rv   = ($urandom_range(0, 9) == 0);
            rpc  = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                 : RPC + 64'($urandom_range(0, 1023));
            resp = 1'b0;
            if (m_out) begin
                if (wcnt == 0) resp = 1'b1;
                else wcnt--;
            end else if (!m_idle && $urandom_range(0, 19) == 0) begin
                resp = 1'b1;
            end
            if (!rs && !m_idle && !m_out && !m_hold && rdy)
                wcnt = $urandom_range(0, 3);
            cyc(rs, rdy, resp, $urandom, ir, rv, rpc);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_backpressure();
        test_redirect_wait();
        test_redirect_hold();
        test_redirect_req();
        test_reset_wait();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
